// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Selects one requesting channel per cycle, round-robin or by a forced index.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);

    localparam int IDX_SPAN = 1 << SEL_W;

    logic                   valid_q, valid_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [SEL_W-1:0]       ch_q, ch_d;
    logic [SEL_W-1:0]       ptr_q, ptr_d;

    logic                   accept;
    logic                   rr_vld;
    logic [SEL_W-1:0]       rr_idx;
    logic                   force_hit;
    logic                   grant_vld;
    logic [SEL_W-1:0]       grant_idx;
    logic [IDX_SPAN-1:0]    valid_ext;
    logic [WIDTH-1:0]       grant_data;
    logic [WIDTH-1:0]       ch_data [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = accept & grant_vld & (grant_idx == SEL_W'(gi));
        end
    endgenerate

    assign accept = ~valid_q | out_ready;

    // Indices beyond N_CH-1 read as never-valid, so an out-of-range force_sel cannot grant.
    always_comb begin
        valid_ext             = '0;
        valid_ext[N_CH-1:0]   = in_valid;
    end

    assign force_hit = valid_ext[force_sel];

    // Scan from the highest offset down so the nearest requester after ptr wins.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            int unsigned idx;
            idx = int'(ptr_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (in_valid[idx]) begin
                rr_vld = 1'b1;
                rr_idx = SEL_W'(idx);
            end
        end
    end

    assign grant_vld = force_en ? force_hit : rr_vld;
    assign grant_idx = force_en ? force_sel : rr_idx;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = ch_data[i];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (grant_vld) begin
                valid_d = 1'b1;
                data_d  = grant_data;
                ch_d    = grant_idx;
                if (!force_en) begin
                    ptr_d = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance checked against
// hand-written vectors and a queue-free behavioural model of the arbitration rules.
module tb_stream_mux_rr;

    logic clk;
    logic rst_n;

    logic [3:0]  v4;
    logic [31:0] d4;
    logic [3:0]  rdy4;
    logic        fe4;
    logic [1:0]  fs4;
    logic        ov4;
    logic [7:0]  od4;
    logic [1:0]  oc4;
    logic        or4;

    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  rdy3;
    logic        fe3;
    logic [1:0]  fs3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        or3;

    int checks;
    int failures;

    int         m_ptr  [2];
    logic       m_ov   [2];
    logic [7:0] m_data [2];
    int         m_ch   [2];
    logic [3:0] rdy_seen [2];

    typedef struct {
        logic [3:0] v;
        logic       fe;
        logic [1:0] fs;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_ch;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl [18];

    stream_mux_rr #(.WIDTH(8), .N_CH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_data(d4), .in_ready(rdy4),
        .force_en(fe4), .force_sel(fs4),
        .out_valid(ov4), .out_data(od4), .out_ch(oc4), .out_ready(or4)
    );

    stream_mux_rr #(.WIDTH(8), .N_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .force_en(fe3), .force_sel(fs3),
        .out_valid(ov3), .out_data(od3), .out_ch(oc3), .out_ready(or3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_grant(input int d, input int n, input logic [3:0] v,
                                   input logic fe, input int fs);
        if (fe) begin
            if (fs < n && v[fs]) return fs;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (m_ptr[d] + k) % n;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]  = 0;
            m_ov[d]   = 1'b0;
            m_data[d] = 8'h00;
            m_ch[d]   = 0;
        end
    endtask

    task automatic get_in(input int d, output int n, output logic [3:0] v, output logic fe,
                          output int fs, output logic ordy);
        if (d == 0) begin
            n = 4; v = v4; fe = fe4; fs = int'(fs4); ordy = or4;
        end else begin
            n = 3; v = {1'b0, v3}; fe = fe3; fs = int'(fs3); ordy = or3;
        end
    endtask

    // One clock: check ready before the edge, advance the model, check the register after it.
    task automatic tick();
        int n, fs, g;
        logic [3:0] v, er, act;
        logic fe, ordy, acc;
        #1;
        for (int d = 0; d < 2; d++) begin
            get_in(d, n, v, fe, fs, ordy);
            acc = !m_ov[d] || ordy;
            g = m_grant(d, n, v, fe, fs);
            er = (acc && g >= 0) ? (4'b0001 << g) : 4'b0000;
            act = (d == 0) ? rdy4 : {1'b0, rdy3};
            rdy_seen[d] = act;
            chk(d == 0 ? "m4_ready" : "m3_ready", 32'(act), 32'(er));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            get_in(d, n, v, fe, fs, ordy);
            acc = !m_ov[d] || ordy;
            g = m_grant(d, n, v, fe, fs);
            if (acc) begin
                if (g >= 0) begin
                    m_ov[d]   = 1'b1;
                    m_data[d] = (d == 0) ? d4[g*8 +: 8] : d3[g*8 +: 8];
                    m_ch[d]   = g;
                    if (!fe) m_ptr[d] = (g + 1) % n;
                end else begin
                    m_ov[d] = 1'b0;
                end
            end
        end
        #1;
        chk("m4_valid", 32'(ov4), 32'(m_ov[0]));
        chk("m4_data",  32'(od4), 32'(m_data[0]));
        chk("m4_ch",    32'(oc4), 32'(m_ch[0]));
        chk("m3_valid", 32'(ov3), 32'(m_ov[1]));
        chk("m3_data",  32'(od3), 32'(m_data[1]));
        chk("m3_ch",    32'(oc3), 32'(m_ch[1]));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_reset();
        rst_n = 1'b1;
        v4 = '0; d4 = 32'h335AC310; fe4 = 1'b0; fs4 = '0; or4 = 1'b1;
        v3 = '0; d3 = 24'h221100;   fe3 = 1'b0; fs3 = '0; or3 = 1'b1;

        // in_valid, force_en, force_sel, out_ready, exp ready, exp out_valid, out_ch, out_data
        tbl[0]  = '{4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5A};
        tbl[1]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[2]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[3]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hC3};
        tbl[4]  = '{4'b0100, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hC3};
        tbl[5]  = '{4'b0100, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hC3};
        tbl[6]  = '{4'b0100, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hC3};
        tbl[7]  = '{4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5A};
        tbl[8]  = '{4'b1111, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[9]  = '{4'b1111, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[10] = '{4'b0111, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h33};
        tbl[11] = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[12] = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[13] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h10};
        tbl[14] = '{4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h10};
        tbl[15] = '{4'b0010, 1'b1, 2'd1, 1'b0, 4'b0010, 1'b1, 2'd1, 8'hC3};
        tbl[16] = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hC3};
        tbl[17] = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hC3};

        // Power-on reset: outputs clear while rst_n is low, before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(ov4), 32'd0);
        chk("rst_data",  32'(od4), 32'd0);
        chk("rst_ch",    32'(oc4), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            v4 = tbl[i].v; fe4 = tbl[i].fe; fs4 = tbl[i].fs; or4 = tbl[i].ordy;
            tick();
            chk($sformatf("tbl%0d_ready", i), 32'(rdy_seen[0]), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(ov4), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_ch", i),    32'(oc4), 32'(tbl[i].e_ch));
            chk($sformatf("tbl%0d_data", i),  32'(od4), 32'(tbl[i].e_data));
        end

        // Asynchronous reset between edges while a word is held.
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov4), 32'd0);
        chk("mid_rst_data",  32'(od4), 32'd0);
        chk("mid_rst_ch",    32'(oc4), 32'd0);
        m_reset();
        v4 = 4'b0000; fe4 = 1'b0; or4 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fairness after reset: all channels valid, data equals channel number.
        v4 = 4'b1111; d4 = 32'h03020100;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) chk("post_rst_ready", 32'(rdy_seen[0]), 32'h1);
            chk($sformatf("rr%0d_valid", i), 32'(ov4), 32'd1);
            chk($sformatf("rr%0d_ch", i),    32'(oc4), 32'(i % 4));
            chk($sformatf("rr%0d_data", i),  32'(od4), 32'(i % 4));
        end
        v4 = 4'b0000;

        // Three-channel instance: out-of-range forced select never grants, then wrap 0,1,2,0.
        v3 = 3'b111; fe3 = 1'b1; fs3 = 2'd3; or3 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("n3_force3_ready", 32'(rdy_seen[1]), 32'd0);
            chk("n3_force3_valid", 32'(ov3), 32'd0);
        end
        fe3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("n3_wrap%0d_ch", i),   32'(oc3), 32'(i % 3));
            chk($sformatf("n3_wrap%0d_data", i), 32'(od3), 32'(8'h11 * (i % 3)));
        end

        // Randomised traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            v4  = 4'($urandom);
            d4  = $urandom;
            fe4 = ($urandom_range(3) == 0);
            fs4 = 2'($urandom);
            or4 = ($urandom_range(3) != 0);
            v3  = 3'($urandom);
            d3  = 24'($urandom);
            fe3 = ($urandom_range(3) == 0);
            fs3 = 2'($urandom);
            or3 = ($urandom_range(3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel streaming multiplexer with a valid/ready handshake on every channel and a registered output stage. Each cycle it selects one requesting input channel, either round-robin or by an externally forced select, and moves that word into the output register with one cycle of latency and full throughput. It sits wherever several producers share one consumer, such as a register-file write port or a shared bus master. It supersedes the plain combinational 4:1 select muxes for streaming traffic.

## Interface
- WIDTH, 8: data width per channel, ≥1.
- N_CH, 4: number of input channels, ≥2, not required to be a power of two.
- SEL_W, $clog2(N_CH): width of channel index fields. Derived, never overridden.
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  N_CH  per-channel valid. Bit i belongs to channel i.
- in_data  input  N_CH*WIDTH  flattened data. Channel i is in_data[i*WIDTH +: WIDTH].
- in_ready  output  N_CH  per-channel ready, combinational.
- force_en  input  1  1 selects forced mode, 0 selects round-robin mode.
- force_sel  input  SEL_W  channel index used in forced mode.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  held word.
- out_ch  output  SEL_W  source channel of the held word.
- out_ready  input  1  consumer accepts the word.

## Operation
- accept = !out_valid | out_ready. The register can load when it is empty or being drained in the same cycle.
- State: output register (out_valid, out_data, out_ch) and round-robin pointer ptr (SEL_W bits, range 0..N_CH-1).
- Round-robin mode (force_en=0): grant goes to the first i with in_valid[i]=1, scanning ptr, ptr+1, …, N_CH-1, 0, …, ptr-1.
- Forced mode (force_en=1): grant goes to force_sel only if force_sel < N_CH and in_valid[force_sel]=1. Otherwise there is no grant. Other channels are never granted in this mode.
- in_ready[g] = accept & (g is the granted channel). All other bits of in_ready are 0. Ready may depend combinationally on in_valid, force_en, force_sel and out_ready. Producers must not make valid depend on ready.
- Transfer on channel g happens when in_valid[g] & in_ready[g]. On the next edge: out_data = in_data[g], out_ch = g, out_valid = 1.
- After a round-robin transfer, ptr becomes (g+1) mod N_CH, wrapping at N_CH-1 to 0.
- A forced transfer leaves ptr unchanged.
- If accept=1 and there is no grant, out_valid becomes 0 on the next edge. out_data and out_ch hold their values.
- If accept=0, the output register and ptr hold. out_data and out_ch are stable while out_valid=1 and out_ready=0.
- Switching force_en or force_sel mid-stream is legal and takes effect the same cycle. A word already in the output register is unaffected.

## Timing
- Latency is 1 cycle from an input transfer to out_valid=1.
- Throughput is 1 word/cycle when out_ready is held at 1.
- Simultaneous drain and load (out_valid=1, out_ready=1, grant present): the new word replaces the old one with no bubble.
- Reset (rst_n=0, asynchronous assert, synchronous-to-clk deassert by system convention) forces out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is then purely combinational and equals the grant, since accept=1.
- Reset mid-operation discards the held word. The first post-reset round-robin grant favours channel 0.
- No combinational path from in_data to any output.

## Test plan
- Reset and single transfer: assert rst_n=0 with out_valid=1, then release. Require out_valid=0, out_data=0 and out_ch=0 immediately. Then drive in_valid=4'b0100 with ch2 data 8'h5A and out_ready=1. Require in_ready=4'b0100 and, next cycle, out_valid=1, out_data=8'h5A, out_ch=2.
- Round-robin fairness: all four channels valid continuously, data equal to channel number, out_ready=1. Require out_ch sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Backpressure: hold out_ready=0 for 3 cycles while the output register holds ch1 word 8'hC3 and ch2 stays valid. Require out_data to stay 8'hC3, in_ready=0 and ptr unchanged. Then release out_ready. Require ch2 to be loaded the same cycle the ch1 word drains.
- Forced mode: force_en=1, force_sel=3, all channels valid. Require only in_ready[3]=1 and out_ch=3 every cycle. Then drop in_valid[3]. Require in_ready=0 and out_valid to go to 0. Then return to force_en=0 and require the scan to resume from the unchanged ptr.
- Non-power-of-two N_CH=3: force_sel=3 with all valid. Require no grant. In round-robin mode, require the ptr wrap sequence 0,1,2,0.
- Reset mid-stream: assert rst_n asynchronously between edges while out_valid=1. Require out_valid=0 without waiting for a clock edge, and a first post-reset grant to channel 0 with all channels valid.
